// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative RV32M multiply/divide unit for the execute stage.
// Multiply is a 32-step shift-add on operand magnitudes; divide is a 32-step
// restoring divider sharing the same accumulator/shift registers. Signs are
// applied once, when the final result is registered on entry to DONE.
// Build option: define MULDIV_DIV_EN to include the divider. Without it,
// DIV/DIVU/REM/REMU requests complete after one stall cycle with result 0.
module muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StartE,
    input  logic [2:0]      Funct3E,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic [4:0]      RdE,
    input  logic            FlushE,
    output logic            StallE,
    output logic            DoneE,
    output logic [XLEN-1:0] ResultE,
    output logic [4:0]      RdOutE,
    output logic            BusyE
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
`ifdef MULDIV_DIV_EN
    localparam logic [1:0] S_DIV  = 2'd2;
`endif
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;     // product high word / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;       // multiplier / dividend-then-quotient
    logic [XLEN-1:0] op_q, op_d;       // multiplicand or divisor magnitude
    logic [1:0]      f3_q, f3_d;       // low op bits: selects word / quotient vs remainder
    logic            qneg_q, qneg_d;   // product or quotient must be negated
    logic [4:0]      tag_q, tag_d;     // destination of the in-flight op
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] result_q, result_d;

    // Operand sign handling at accept time
    logic            accept;
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    // Decode operand signedness and form magnitudes
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (Funct3E)
            3'b000, 3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
            3'b010:                         begin a_signed = 1'b1; b_signed = 1'b0; end
            default:                        begin a_signed = 1'b0; b_signed = 1'b0; end
        endcase
        a_neg = a_signed & SrcAE[XLEN-1];
        b_neg = b_signed & SrcBE[XLEN-1];
        a_mag = a_neg ? (~SrcAE + 1'b1) : SrcAE;
        b_mag = b_neg ? (~SrcBE + 1'b1) : SrcBE;
    end

    assign accept = (state_q == S_IDLE) & StartE & ~FlushE;

    // One shift-add multiply step and the signed final product
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_acc_nxt, mul_lo_nxt, mul_res;
    logic [2*XLEN-1:0] prod, prod_s;

    always_comb begin
        mul_sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, op_q} : '0);
        mul_acc_nxt = mul_sum[XLEN:1];
        mul_lo_nxt  = {mul_sum[0], lo_q[XLEN-1:1]};
        prod        = {mul_acc_nxt, mul_lo_nxt};
        prod_s      = qneg_q ? (~prod + 1'b1) : prod;
        mul_res     = (f3_q == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end

`ifdef MULDIV_DIV_EN
    logic            rneg_q, rneg_d;   // remainder takes the dividend's sign
    logic [XLEN:0]   div_shift, div_trial;
    logic            div_ge;
    logic [XLEN-1:0] div_rem_nxt, div_quo_nxt, div_res;
    logic            div_zero, div_ovf;

    // One restoring divide step; remainder < divisor keeps the trial within XLEN bits
    always_comb begin
        div_shift   = {acc_q, lo_q[XLEN-1]};
        div_trial   = div_shift - {1'b0, op_q};
        div_ge      = ~div_trial[XLEN];
        div_rem_nxt = div_ge ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
        div_quo_nxt = {lo_q[XLEN-2:0], div_ge};
        if (f3_q[1])
            div_res = rneg_q ? (~div_rem_nxt + 1'b1) : div_rem_nxt;
        else
            div_res = qneg_q ? (~div_quo_nxt + 1'b1) : div_quo_nxt;
        div_zero = (SrcBE == '0);
        div_ovf  = ~Funct3E[0] & (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (&SrcBE);
    end
`endif

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        op_d     = op_q;
        f3_d     = f3_q;
        qneg_d   = qneg_q;
        tag_d    = tag_q;
        rd_d     = rd_q;
        result_d = result_q;
`ifdef MULDIV_DIV_EN
        rneg_d   = rneg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d  = '0;
                    acc_d  = '0;
                    f3_d   = Funct3E[1:0];
                    qneg_d = a_neg ^ b_neg;
                    tag_d  = RdE;
                    if (!Funct3E[2]) begin
                        state_d = S_MUL;
                        op_d    = a_mag;
                        lo_d    = b_mag;
                    end else begin
`ifdef MULDIV_DIV_EN
                        rneg_d = a_neg;
                        op_d   = b_mag;
                        lo_d   = a_mag;
                        if (div_zero) begin
                            state_d  = S_DONE;
                            rd_d     = RdE;
                            result_d = Funct3E[1] ? SrcAE : '1;
                        end else if (div_ovf) begin
                            state_d  = S_DONE;
                            rd_d     = RdE;
                            result_d = Funct3E[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        end else begin
                            state_d = S_DIV;
                        end
`else
                        state_d  = S_DONE;
                        rd_d     = RdE;
                        result_d = '0;
`endif
                    end
                end
            end
            S_MUL: begin
                if (FlushE) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = mul_acc_nxt;
                    lo_d  = mul_lo_nxt;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d  = S_DONE;
                        rd_d     = tag_q;
                        result_d = mul_res;
                    end
                end
            end
`ifdef MULDIV_DIV_EN
            S_DIV: begin
                if (FlushE) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = div_rem_nxt;
                    lo_d  = div_quo_nxt;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d  = S_DONE;
                        rd_d     = tag_q;
                        result_d = div_res;
                    end
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            op_q     <= '0;
            f3_q     <= '0;
            qneg_q   <= 1'b0;
            tag_q    <= '0;
            rd_q     <= '0;
            result_q <= '0;
`ifdef MULDIV_DIV_EN
            rneg_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            op_q     <= op_d;
            f3_q     <= f3_d;
            qneg_q   <= qneg_d;
            tag_q    <= tag_d;
            rd_q     <= rd_d;
            result_q <= result_d;
`ifdef MULDIV_DIV_EN
            rneg_q   <= rneg_d;
`endif
        end
    end

    // Pipeline handshake outputs; reset suppresses stall and done in its cycle
`ifdef MULDIV_DIV_EN
    assign BusyE  = (state_q == S_MUL) | (state_q == S_DIV);
`else
    assign BusyE  = (state_q == S_MUL);
`endif
    assign StallE  = ~rst & (accept | BusyE);
    assign DoneE   = ~rst & (state_q == S_DONE) & ~FlushE;
    assign ResultE = result_q;
    assign RdOutE  = rd_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed testbench for muldiv_ctrl; expectations are hand-computed.
// Divider expectations follow the MULDIV_DIV_EN build option.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        StartE;
    logic [2:0]  Funct3E;
    logic [31:0] SrcAE, SrcBE;
    logic [4:0]  RdE;
    logic        FlushE;
    logic        StallE, DoneE, BusyE;
    logic [31:0] ResultE;
    logic [4:0]  RdOutE;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] last_exp;
    logic [4:0]  last_rd;

    muldiv_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .StartE(StartE), .Funct3E(Funct3E),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .RdE(RdE), .FlushE(FlushE),
        .StallE(StallE), .DoneE(DoneE), .ResultE(ResultE),
        .RdOutE(RdOutE), .BusyE(BusyE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op, count stall cycles until DoneE, then check result fields
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_stalls);
        int stalls;
        logic done;
        logic [31:0] got_res;
        logic [4:0]  got_rd;
        stalls  = 0;
        done    = 1'b0;
        got_res = '0;
        got_rd  = '0;
        @(negedge clk);
        StartE = 1'b1; Funct3E = f3; SrcAE = a; SrcBE = b; RdE = rd;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (StallE) stalls++;
            if (DoneE) begin
                done    = 1'b1;
                got_res = ResultE;
                got_rd  = RdOutE;
                break;
            end
            @(posedge clk);
            #1;
            StartE = 1'b0;
        end
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " stalls"}, stalls, exp_stalls);
        check({tag, " result"}, got_res, exp_res);
        check({tag, " rd"}, {27'd0, got_rd}, {27'd0, rd});
        @(posedge clk);
        #1;
        check({tag, " done pulse width"}, {31'd0, DoneE}, 32'd0);
        $display("op %-14s f3=%b a=%h b=%h rd=%0d -> result=%h stalls=%0d",
                 tag, f3, a, b, rd, got_res, stalls);
        last_exp = exp_res;
        last_rd  = rd;
    endtask

    initial begin
        logic saw_done;
        rst = 1'b1; StartE = 1'b0; Funct3E = '0; SrcAE = '0; SrcBE = '0;
        RdE = '0; FlushE = 1'b0;
        last_exp = '0; last_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ResultE", ResultE, 32'd0);
        check("reset RdOutE", {27'd0, RdOutE}, 32'd0);
        check("reset DoneE", {31'd0, DoneE}, 32'd0);
        check("reset BusyE", {31'd0, BusyE}, 32'd0);
        check("reset StallE", {31'd0, StallE}, 32'd0);
        rst = 1'b0;

        run_op("MUL",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33);
        run_op("MULHU",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 33);
        run_op("MULH",   3'b001, 32'h80000000, 32'h80000000, 5'd7,  32'h40000000, 33);
        run_op("MULHSU", 3'b010, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 33);
`ifdef MULDIV_DIV_EN
        run_op("DIV",      3'b100, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 33);
        run_op("REM",      3'b110, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 33);
        run_op("DIVU",     3'b101, 32'd100,      32'd7,        5'd12, 32'd14,       33);
        run_op("REMU",     3'b111, 32'd100,      32'd7,        5'd13, 32'd2,        33);
        run_op("DIVU by0", 3'b101, 32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, 1);
        run_op("REMU by0", 3'b111, 32'd5,        32'd0,        5'd15, 32'd5,        1);
        run_op("REM by0",  3'b110, 32'hFFFFFFF9, 32'd0,        5'd16, 32'hFFFFFFF9, 1);
        run_op("DIV ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 1);
        run_op("REM ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0,        1);
        run_op("DIVU big", 3'b101, 32'hFFFFFFFF, 32'd16,       5'd19, 32'h0FFFFFFF, 33);
`else
        run_op("DIV nodiv",  3'b100, 32'd10, 32'd2, 5'd10, 32'd0, 1);
        run_op("REMU nodiv", 3'b111, 32'd5,  32'd3, 5'd11, 32'd0, 1);
`endif
        run_op("MUL again", 3'b000, 32'd1000, 32'd3, 5'd20, 32'd3000, 33);

        // Flush at iteration 10: abort with no done pulse and result retained
        @(negedge clk);
        StartE = 1'b1; Funct3E = 3'b000; SrcAE = 32'd3; SrcBE = 32'd5; RdE = 5'd9;
        @(posedge clk); #1; StartE = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        FlushE = 1'b1;
        #1;
        check("flush busy before", {31'd0, BusyE}, 32'd1);
        @(posedge clk); #1; FlushE = 1'b0;
        check("flush busy after", {31'd0, BusyE}, 32'd0);
        check("flush stall after", {31'd0, StallE}, 32'd0);
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (DoneE) saw_done = 1'b1;
        end
        check("flush no done", {31'd0, saw_done}, 32'd0);
        check("flush result kept", ResultE, last_exp);
        check("flush rd kept", {27'd0, RdOutE}, {27'd0, last_rd});
        $display("op FLUSH@10      -> result=%h rd=%0d", ResultE, RdOutE);

        // Reset at iteration 10, with a start request that must lose to reset
        @(negedge clk);
        StartE = 1'b1; Funct3E = 3'b000; SrcAE = 32'd3; SrcBE = 32'd5; RdE = 5'd9;
        @(posedge clk); #1; StartE = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1; StartE = 1'b1;
        @(posedge clk); #1; rst = 1'b0; StartE = 1'b0;
        #1;
        check("rst busy", {31'd0, BusyE}, 32'd0);
        check("rst result", ResultE, 32'd0);
        check("rst rd", {27'd0, RdOutE}, 32'd0);
        check("rst done", {31'd0, DoneE}, 32'd0);
        $display("op RESET@10      -> result=%h rd=%0d", ResultE, RdOutE);

        run_op("MUL post-rst", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 32'd1, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: StartE  input  1  M-extension instruction valid in execute stage.
REQ-005 SHALL have port: Funct3E  input  3  op select; 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have ports: SrcAE and SrcBE, each input, 32 bits; operand A (multiplicand/dividend) and operand B (multiplier/divisor).
REQ-007 SHALL have port: RdE  input  5  destination register of the requesting instruction.
REQ-008 SHALL have port: FlushE  input  1  kill of the execute-stage instruction (branch/jump redirect).
REQ-009 SHALL have port: StallE  output  1  freeze fetch, decode and execute pipeline registers.
REQ-010 SHALL have port: DoneE  output  1  one-cycle pulse; ResultE valid.
REQ-011 SHALL have port: ResultE  output  32  registered result.
REQ-012 SHALL have port: RdOutE  output  5  captured destination register.
REQ-013 SHALL have port: BusyE  output  1  high in MUL or DIV state.

Function
REQ-014 SHALL implement states IDLE, MUL, DIV, DONE with a 5-bit iteration counter.
REQ-015 SHALL accept a request in IDLE when StartE=1 and FlushE=0: latch magnitudes of the operands per the op's signedness, latch result-sign flags and RdE, clear the counter, and go to MUL if Funct3E[2]=0, else DIV.
REQ-016 SHALL drive StallE = (IDLE & StartE & ~FlushE) | MUL | DIV; StallE SHALL be 0 in DONE.
REQ-017 SHALL process one bit per cycle in MUL (shift-add, 64-bit product) and DIV (restoring), transitioning to DONE when the counter reaches 31.
REQ-018 SHALL enter DONE 33 cycles after the accept cycle, for 33 total StallE cycles.
REQ-019 SHALL, in DONE, assert DoneE = ~FlushE, update ResultE with the sign-corrected low or high product word, quotient, or remainder, and return to IDLE next cycle; StartE is ignored in DONE.
REQ-020 SHALL, for a zero divisor detected at accept, go directly to DONE with 1 stall cycle; the result is quotient 0xFFFFFFFF and remainder = dividend.
REQ-021 SHALL, for signed overflow (DIV/REM of 0x80000000 by 0xFFFFFFFF) detected at accept, go directly to DONE; the result is quotient 0x80000000 and remainder 0.
REQ-022 SHALL negate the quotient when operand signs differ, and SHALL give the remainder the sign of the dividend.
REQ-023 SHALL, on FlushE=1 in MUL or DIV, abort to IDLE next cycle with no DoneE pulse and ResultE unchanged.
REQ-024 SHALL hold ResultE and RdOutE until the next DONE.

Reset
REQ-025 SHALL, on rst=1 at a clock edge in any state, go to IDLE, set counter and all registers to 0, and force ResultE=0, RdOutE=0, DoneE=0 and BusyE=0; StallE is 0 unless StartE is asserted.
REQ-026 SHALL have rst take priority over StartE and FlushE in the same cycle.

Configuration
REQ-027 SHALL, with MULDIV_DIV_EN defined, implement the DIV state, divider datapath, and REQ-020 through REQ-022.
REQ-028 SHALL, without MULDIV_DIV_EN, omit the DIV state and divider logic; a Funct3E[2]=1 request is accepted and goes directly to DONE with ResultE=0 and 1 stall cycle.

Verification
REQ-029 SHALL cover: MUL 7 x 0xFFFFFFFD, RdE=5 -> StallE high 33 cycles, then DoneE pulse with ResultE=0xFFFFFFEB and RdOutE=5.
REQ-030 SHALL cover: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> ResultE=0xFFFFFFFE; MULH 0x80000000 x 0x80000000 -> 0x40000000.
REQ-031 SHALL cover: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU of the same operands -> 2.
REQ-032 SHALL cover: DIVU 5/0 -> 1 stall cycle, ResultE=0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-033 SHALL cover: FlushE at iteration 10 -> IDLE next cycle, no DoneE, ResultE keeps its prior value; rst at iteration 10 -> IDLE, ResultE=0.
REQ-034 SHALL cover, with MULDIV_DIV_EN undefined: DIV 10/2 -> 1 stall cycle, DoneE pulse, ResultE=0.
